stage_execute: RTL and testbench
================================

Name: stage_execute

Overview:
- Vector execute stage of the ASIP pipeline, directly upstream of the writeback/memory stage.
- Applies a per-lane ALU operation to two vector operands.
- Registers the result together with the sideband that writeback consumes: aluResult, alu_operand1, alu_operand2, imm, writeEnable, writeMemFrom, writeRegFrom.
- Single-cycle ops issue every cycle. Vector multiply is iterative and multi-cycle, and stalls upstream while it runs.

Parameters:
- vecSize, 4, number of lanes per vector.
- registerSize, 16, bits per lane, also the imm width.

Ports:
- clk  input  1  pipeline clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous; kills the in-flight instruction.
- valid_in  input  1  decode presents a valid instruction.
- aluControl  input  4  operation select.
- operand1  input  vecSize x registerSize  source A.
- operand2  input  vecSize x registerSize  source B.
- imm_in  input  registerSize  immediate, passed through.
- writeEnable_in  input  1  memory write request.
- writeMemFrom_in  input  1  writeback address/data select.
- writeRegFrom_in  input  2  writeback register source select.
- stall  output  1  upstream must hold all inputs this cycle.
- valid_out  output  1  output register holds a valid instruction.
- aluResult  output  vecSize x registerSize  registered result.
- alu_operand1  output  vecSize x registerSize  registered copy of operand1.
- alu_operand2  output  vecSize x registerSize  registered copy of operand2.
- imm  output  registerSize  registered imm_in.
- writeEnable  output  1  registered writeEnable_in, gated by valid.
- writeMemFrom  output  1  registered writeMemFrom_in.
- writeRegFrom  output  2  registered writeRegFrom_in.

Behaviour:
- Operations are per lane, with results truncated to registerSize (no carry out, no flags):
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL: a << b[3:0]
  - 6 SHR: logical, a >> b[3:0]
  - 7 MUL: low registerSize bits of a*b, multi-cycle
  - 8 PASSA: a
  - 9 PASSB: b
  - 10-15: result 0
- FSM states are IDLE and MUL.
- Accept condition: state==IDLE && valid_in && !flush.
- Non-MUL op accepted: the output register loads result and sideband at that edge and valid_out=1 the following cycle. Latency is 1, throughput 1 per cycle.
- No accept in IDLE: valid_out=0 next cycle; writeEnable=0.
  - Data outputs hold their previous values; they are don't-care for downstream.
- MUL accepted:
  - Latch operands and sideband into internal registers.
  - Clear the accumulator; counter=0.
  - Go to MUL. valid_out=0 next cycle.
- MUL state:
  - Each cycle, every lane does one shift-add step: if multiplier bit[counter] is set, acc += multiplicand << counter. Counter increments.
  - After registerSize steps (counter==registerSize-1 step done), load the output register with acc and the latched sideband, set valid_out=1, return to IDLE.
  - Total: product is visible registerSize+1 cycles after the accept edge.
- stall = (state==MUL), combinational.
  - valid_in and all inputs are ignored while in MUL.
  - stall is 0 in the cycle valid_out carries the product, so a new instruction may be accepted that same cycle.
- writeEnable output = registered writeEnable_in AND valid. It is never 1 while valid_out=0.
- flush has priority over accept and MUL progress:
  - Next cycle: valid_out=0, writeEnable=0, state=IDLE, stall=0.
  - Any partial product is discarded.
- reset has priority over flush and sets:
  - state=IDLE, counter=0, acc=0
  - valid_out=0, stall=0, writeEnable=0, writeMemFrom=0, writeRegFrom=0
  - aluResult=0, alu_operand1=0, alu_operand2=0, imm=0
- Reset asserted mid-MUL aborts the MUL identically to flush, plus clears the outputs.
- SHL/SHR use only b[3:0]; upper shift bits are ignored (shift by 16 impossible).

Test Plan:
- Reset, then ADD with lane values a={1,2,3,0xFFFF}, b={1,1,1,1} -> one cycle later valid_out=1, aluResult={2,3,4,0x0000}; sideband registered unchanged; stall always 0.
- Back-to-back SUB, XOR, SHL (a=0x0001, b=0x0013) -> three consecutive valid_out cycles; SHL lanes = 0x0008; SUB 0-1 gives 0xFFFF.
- MUL a={3,0x0100,0xFFFF,7}, b={5,0x0100,2,0} -> stall=1 for exactly 16 cycles, valid_out=0 during them; then aluResult={15,0x0000,0xFFFE,0}; an ADD held on the inputs during the stall is accepted the cycle stall drops and appears next cycle.
- flush on the 5th MUL cycle -> next cycle stall=0, valid_out=0, writeEnable=0; a following ADD completes normally with latency 1.
- Accept a store (writeEnable_in=1, writeMemFrom_in=1), then valid_in=0 -> writeEnable=1 for exactly one cycle, then 0.
- Assert reset mid-MUL -> next cycle all outputs 0 and stall=0.
- aluControl=12 -> aluResult=0 with valid_out=1.

Source files
------------

// File: rtl/stage_execute.sv
// Vector execute stage: per-lane single-cycle ALU plus an iterative shift-add
// multiplier that stalls upstream while it runs.
module stage_execute #(
  parameter int unsigned vecSize      = 4,
  parameter int unsigned registerSize = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic                                  valid_in,
  input  logic [3:0]                            aluControl,
  input  logic [vecSize-1:0][registerSize-1:0]  operand1,
  input  logic [vecSize-1:0][registerSize-1:0]  operand2,
  input  logic [registerSize-1:0]               imm_in,
  input  logic                                  writeEnable_in,
  input  logic                                  writeMemFrom_in,
  input  logic [1:0]                            writeRegFrom_in,
  output logic                                  stall,
  output logic                                  valid_out,
  output logic [vecSize-1:0][registerSize-1:0]  aluResult,
  output logic [vecSize-1:0][registerSize-1:0]  alu_operand1,
  output logic [vecSize-1:0][registerSize-1:0]  alu_operand2,
  output logic [registerSize-1:0]               imm,
  output logic                                  writeEnable,
  output logic                                  writeMemFrom,
  output logic [1:0]                            writeRegFrom
);

  localparam int unsigned CNT_W = $clog2(registerSize);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(registerSize - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SHL   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_PASSA = 4'd8;
  localparam logic [3:0] OP_PASSB = 4'd9;

  logic [0:0] state_q, state_d;
  logic       accept, accept_mul, accept_alu, mul_step, mul_done;

  logic [vecSize-1:0][registerSize-1:0] alu_res;
  logic [vecSize-1:0][registerSize-1:0] acc_q, acc_d;
  logic [vecSize-1:0][registerSize-1:0] lat_op1_q, lat_op2_q;
  logic [registerSize-1:0]              lat_imm_q;
  logic                                 lat_we_q, lat_wmf_q;
  logic [1:0]                           lat_wrf_q;
  logic [CNT_W-1:0]                     cnt_q;

  assign stall = (state_q == MUL);

  // Next-state and handshake decode; flush beats both accept and MUL progress.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    accept_mul = 1'b0;
    accept_alu = 1'b0;
    mul_step   = 1'b0;
    mul_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && !flush) begin
          accept = 1'b1;
          if (aluControl == OP_MUL) begin
            accept_mul = 1'b1;
            state_d    = MUL;
          end else begin
            accept_alu = 1'b1;
          end
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          mul_step = 1'b1;
          if (cnt_q == CNT_LAST) begin
            mul_done = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Single-cycle per-lane ALU; MUL and reserved codes produce zero here.
  always_comb begin
    alu_res = '0;
    for (int unsigned l = 0; l < vecSize; l++) begin
      case (aluControl)
        OP_ADD:   alu_res[l] = operand1[l] + operand2[l];
        OP_SUB:   alu_res[l] = operand1[l] - operand2[l];
        OP_AND:   alu_res[l] = operand1[l] & operand2[l];
        OP_OR:    alu_res[l] = operand1[l] | operand2[l];
        OP_XOR:   alu_res[l] = operand1[l] ^ operand2[l];
        OP_SHL:   alu_res[l] = operand1[l] << operand2[l][CNT_W-1:0];
        OP_SHR:   alu_res[l] = operand1[l] >> operand2[l][CNT_W-1:0];
        OP_PASSA: alu_res[l] = operand1[l];
        OP_PASSB: alu_res[l] = operand2[l];
        default:  alu_res[l] = '0;
      endcase
    end
  end

  // One shift-add step per lane, multiplier bit selected by the step counter.
  always_comb begin
    acc_d = acc_q;
    for (int unsigned l = 0; l < vecSize; l++) begin
      if (lat_op2_q[l][cnt_q]) acc_d[l] = acc_q[l] + (lat_op1_q[l] << cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      lat_op1_q    <= '0;
      lat_op2_q    <= '0;
      lat_imm_q    <= '0;
      lat_we_q     <= 1'b0;
      lat_wmf_q    <= 1'b0;
      lat_wrf_q    <= '0;
      valid_out    <= 1'b0;
      writeEnable  <= 1'b0;
      writeMemFrom <= 1'b0;
      writeRegFrom <= '0;
      aluResult    <= '0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      imm          <= '0;
    end else begin
      valid_out   <= 1'b0;
      writeEnable <= 1'b0;
      if (accept_alu) begin
        valid_out    <= 1'b1;
        writeEnable  <= writeEnable_in;
        writeMemFrom <= writeMemFrom_in;
        writeRegFrom <= writeRegFrom_in;
        aluResult    <= alu_res;
        alu_operand1 <= operand1;
        alu_operand2 <= operand2;
        imm          <= imm_in;
      end
      if (accept_mul) begin
        acc_q     <= '0;
        cnt_q     <= '0;
        lat_op1_q <= operand1;
        lat_op2_q <= operand2;
        lat_imm_q <= imm_in;
        lat_we_q  <= writeEnable_in;
        lat_wmf_q <= writeMemFrom_in;
        lat_wrf_q <= writeRegFrom_in;
      end
      if (mul_step) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (mul_done) begin
        valid_out    <= 1'b1;
        writeEnable  <= lat_we_q;
        writeMemFrom <= lat_wmf_q;
        writeRegFrom <= lat_wrf_q;
        aluResult    <= acc_d;
        alu_operand1 <= lat_op1_q;
        alu_operand2 <= lat_op2_q;
        imm          <= lat_imm_q;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = accept;

endmodule

// File: tb/tb_stage_execute.sv
// Directed bench for stage_execute: ALU ops, iterative MUL, stall, flush, reset.
module tb_stage_execute;

  logic        clk = 1'b0;
  logic        reset, flush, valid_in;
  logic [3:0]  aluControl;
  logic [3:0][15:0] operand1, operand2;
  logic [15:0] imm_in;
  logic        writeEnable_in, writeMemFrom_in;
  logic [1:0]  writeRegFrom_in;
  logic        stall, valid_out;
  logic [3:0][15:0] aluResult, alu_operand1, alu_operand2;
  logic [15:0] imm;
  logic        writeEnable, writeMemFrom;
  logic [1:0]  writeRegFrom;

  int tests = 0;
  int fails = 0;

  stage_execute #(.vecSize(4), .registerSize(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
    .aluControl(aluControl), .operand1(operand1), .operand2(operand2),
    .imm_in(imm_in), .writeEnable_in(writeEnable_in),
    .writeMemFrom_in(writeMemFrom_in), .writeRegFrom_in(writeRegFrom_in),
    .stall(stall), .valid_out(valid_out), .aluResult(aluResult),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .imm(imm),
    .writeEnable(writeEnable), .writeMemFrom(writeMemFrom),
    .writeRegFrom(writeRegFrom)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] vec(input logic [15:0] l0, input logic [15:0] l1,
                                      input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    valid_in   = 1'b1;
    aluControl = op;
    operand1   = a;
    operand2   = b;
  endtask

  initial begin
    int stall_cycles;
    logic valid_seen;
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; aluControl = '0;
    operand1 = '0; operand2 = '0; imm_in = '0;
    writeEnable_in = 1'b0; writeMemFrom_in = 1'b0; writeRegFrom_in = '0;
    tick(); tick();
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_result", aluResult, 64'd0);
    check("rst_side", {imm, alu_operand1[0], 1'b0, writeEnable, writeMemFrom, writeRegFrom}, 64'd0);
    reset = 1'b0;

    // ADD with lane wrap and sideband passthrough
    issue(4'd0, vec(1, 2, 3, 16'hFFFF), vec(1, 1, 1, 1));
    imm_in = 16'h1234; writeMemFrom_in = 1'b1; writeRegFrom_in = 2'd2;
    tick();
    check("add_valid", 64'(valid_out), 64'd1);
    check("add_result", aluResult, vec(2, 3, 4, 0));
    check("add_op1", alu_operand1, vec(1, 2, 3, 16'hFFFF));
    check("add_op2", alu_operand2, vec(1, 1, 1, 1));
    check("add_side", {imm, writeMemFrom, writeRegFrom, writeEnable, stall},
          64'({16'h1234, 1'b1, 2'd2, 1'b0, 1'b0}));

    // back-to-back SUB, XOR, SHL, SHR
    imm_in = '0; writeMemFrom_in = 1'b0; writeRegFrom_in = '0;
    issue(4'd1, vec(0, 5, 16'h10, 1), vec(1, 2, 3, 1));
    tick();
    check("sub", {valid_out, aluResult}, 65'({1'b1, vec(16'hFFFF, 3, 16'h000D, 0)}));
    issue(4'd4, vec(16'hF0F0, 16'h00FF, 16'hAAAA, 0), vec(16'h0FF0, 16'h0F0F, 16'h5555, 0));
    tick();
    check("xor", {valid_out, aluResult}, 65'({1'b1, vec(16'hFF00, 16'h0FF0, 16'hFFFF, 0)}));
    issue(4'd5, vec(1, 1, 16'h8001, 16'hFFFF), vec(16'h0013, 3, 1, 16'h00F0));
    tick();
    check("shl", {valid_out, aluResult}, 65'({1'b1, vec(8, 8, 2, 16'hFFFF)}));
    issue(4'd6, vec(16'h8000, 16'hFFFF, 16'h1234, 16'h0100), vec(16'h001F, 4, 0, 16'h0018));
    tick();
    check("shr", {valid_out, aluResult}, 65'({1'b1, vec(1, 16'h0FFF, 16'h1234, 1)}));
    issue(4'd12, vec(5, 6, 7, 8), vec(1, 2, 3, 4));
    tick();
    check("op12", {valid_out, aluResult}, 65'({1'b1, 64'd0}));
    issue(4'd9, vec(5, 6, 7, 8), vec(1, 2, 3, 4));
    tick();
    check("passb", {valid_out, aluResult}, 65'({1'b1, vec(1, 2, 3, 4)}));

    // flush wins over accept in IDLE
    flush = 1'b1;
    tick();
    check("flush_idle", 64'({valid_out, stall}), 64'd0);
    flush = 1'b0;
    valid_in = 1'b0;
    tick();
    check("idle_valid", 64'(valid_out), 64'd0);

    // MUL with an ADD held on the inputs during the stall
    issue(4'd7, vec(3, 16'h0100, 16'hFFFF, 7), vec(5, 16'h0100, 2, 0));
    imm_in = 16'hBEEF; writeRegFrom_in = 2'd1;
    tick();
    issue(4'd0, vec(10, 20, 30, 40), vec(1, 1, 1, 1));
    imm_in = 16'h0055; writeRegFrom_in = 2'd3;
    stall_cycles = 0;
    valid_seen = 1'b0;
    while (stall && stall_cycles < 40) begin
      valid_seen |= valid_out;
      stall_cycles++;
      tick();
    end
    check("mul_stall_len", 64'(stall_cycles), 64'd16);
    check("mul_no_valid", 64'(valid_seen), 64'd0);
    check("mul_result", {valid_out, stall, aluResult}, 66'({2'b10, vec(15, 0, 16'hFFFE, 0)}));
    check("mul_side", {alu_operand1, imm, writeRegFrom}, 82'({vec(3, 16'h0100, 16'hFFFF, 7), 16'hBEEF, 2'd1}));
    tick();
    check("add_after_mul", {valid_out, aluResult, imm}, 81'({1'b1, vec(11, 21, 31, 41), 16'h0055}));

    // flush on the 5th MUL cycle, MUL carries a store
    issue(4'd7, vec(3, 3, 3, 3), vec(3, 3, 3, 3));
    writeEnable_in = 1'b1;
    tick();
    valid_in = 1'b0; writeEnable_in = 1'b0;
    tick(); tick(); tick(); tick();
    check("pre_flush_stall", 64'(stall), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("post_flush", 64'({stall, valid_out, writeEnable}), 64'd0);
    issue(4'd0, vec(100, 200, 300, 400), vec(1, 2, 3, 4));
    tick();
    check("add_after_flush", {valid_out, aluResult}, 65'({1'b1, vec(101, 202, 303, 404)}));

    // store: writeEnable high for exactly one cycle
    issue(4'd3, vec(16'h00F0, 0, 0, 0), vec(16'h000F, 0, 0, 0));
    writeEnable_in = 1'b1; writeMemFrom_in = 1'b1;
    tick();
    check("store_we", 64'({writeEnable, writeMemFrom, valid_out}), 64'b111);
    check("store_or", aluResult, vec(16'h00FF, 0, 0, 0));
    valid_in = 1'b0;
    tick();
    check("store_we_drop", 64'({writeEnable, valid_out}), 64'd0);
    writeEnable_in = 1'b0; writeMemFrom_in = 1'b0;

    // reset mid-MUL clears everything
    issue(4'd7, vec(9, 9, 9, 9), vec(9, 9, 9, 9));
    imm_in = 16'h7777; writeRegFrom_in = 2'd3; writeMemFrom_in = 1'b1;
    tick();
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_mid_mul", {stall, valid_out, writeEnable, writeMemFrom, writeRegFrom, imm},
          22'd0);
    check("rst_mid_data", {aluResult, alu_operand1, alu_operand2}, 192'd0);
    reset = 1'b0;
    valid_in = 1'b0;
    tick();
    check("rst_idle", 64'({stall, valid_out}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
